// File: rtl/alu_multicycle.sv
// alu_multicycle: ALU with NZCV flags and an iterative shift-add multiplier.
// Single-cycle ops finish on the accept edge; MUL takes WIDTH further edges.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       request handshake; op, in1, in2, set_flags captured on accept
//   flush                   synchronous abort of a pending or held result
//   out_valid/out_ready     result handshake; out_data, err held stable until taken
//   flags                   registered {N,Z,C,V}
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             set_flags,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err,
    output logic [3:0]       flags
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_TST = 4'b1100;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand, mplier, acc, mul_sum;
    logic             mul_sf;

    logic [WIDTH-1:0] add_b, res;
    logic [WIDTH:0]   sum;
    logic             add_cin, add_v, is_arith, is_legal, wr_flags, accept;
    logic [3:0]       res_flags;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready && !flush;
    assign mul_sum   = acc + (mplier[0] ? mcand : '0);

    // Single adder serves all four arithmetic ops: subtraction is in1 + ~in2 + cin,
    // so the carry-out is directly NOT borrow and one overflow rule covers both.
    always_comb begin
        add_b    = in2;
        add_cin  = 1'b0;
        is_arith = 1'b0;
        is_legal = 1'b1;
        res      = '0;
        case (op)
            OP_MOV: res = in2;
            OP_MVN: res = ~in2;
            OP_ADD: is_arith = 1'b1;
            OP_ADC: begin
                is_arith = 1'b1;
                add_cin  = flags[1];
            end
            OP_SUB, OP_CMP: begin
                is_arith = 1'b1;
                add_b    = ~in2;
                add_cin  = 1'b1;
            end
            OP_SBC: begin
                is_arith = 1'b1;
                add_b    = ~in2;
                add_cin  = flags[1];
            end
            OP_AND, OP_TST: res = in1 & in2;
            OP_ORR: res = in1 | in2;
            OP_EOR: res = in1 ^ in2;
            OP_MUL: res = '0;
            default: is_legal = 1'b0;
        endcase
        sum   = {1'b0, in1} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        add_v = (in1[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
        if (is_arith) begin
            res = sum[WIDTH-1:0];
        end
        res_flags = {res[WIDTH-1], res == '0, flags[1], flags[0]};
        if (is_arith) begin
            res_flags[1:0] = {sum[WIDTH], add_v};
        end
        wr_flags = is_legal && (set_flags || (op == OP_CMP) || (op == OP_TST));
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else if (accept) begin
            state_nxt = (op == OP_MUL) ? MUL : DONE;
        end else begin
            case (state)
                MUL:     if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            mul_sf   <= 1'b0;
            out_data <= '0;
            err      <= 1'b0;
            flags    <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                cnt <= '0;
            end else if (accept) begin
                if (op == OP_MUL) begin
                    mcand  <= in1;
                    mplier <= in2;
                    acc    <= '0;
                    cnt    <= '0;
                    mul_sf <= set_flags;
                end else begin
                    out_data <= res;
                    err      <= !is_legal;
                    if (wr_flags) begin
                        flags <= res_flags;
                    end
                end
            end else if (state == MUL) begin
                // One multiplier bit per edge; the last step writes the result directly.
                acc    <= mul_sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    out_data <= mul_sum;
                    err      <= 1'b0;
                    cnt      <= '0;
                    if (mul_sf) begin
                        flags[3:2] <= {mul_sum[WIDTH-1], mul_sum == '0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: self-checking bench for alu_multicycle (WIDTH=32).
// Directed scenarios plus randomized operations against a reference model
// that works in wide signed/unsigned integer arithmetic.
module tb_alu_multicycle;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         set_flags = 1'b0;
    logic         flush     = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op        = 4'd0;
    logic [W-1:0] in1       = '0;
    logic [W-1:0] in2       = '0;
    logic         in_ready, out_valid, err;
    logic [W-1:0] out_data;
    logic [3:0]   flags;

    int           checks = 0;
    int           errors = 0;
    logic [3:0]   mf = 4'b0000;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in1(in1), .in2(in2), .set_flags(set_flags), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err(err), .flags(flags)
    );

    // Reference: results and NZCV from plain 64-bit integer arithmetic.
    function automatic void ref_model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                      input logic sf, inout logic [3:0] fl,
                                      output logic [31:0] d, output logic e);
        longint ua, ub, sa, sb, u, s, cin;
        logic   c, v, arith, upd;
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        c = fl[1]; v = fl[0]; e = 1'b0; d = '0; arith = 1'b0; cin = 0;
        upd = sf || (o == 4'd11) || (o == 4'd12);
        case (o)
            4'd1: d = b;
            4'd9: d = ~b;
            4'd2, 4'd3: begin
                if (o == 4'd3) cin = fl[1];
                u = ua + ub + cin; s = sa + sb + cin;
                d = u[31:0]; arith = 1'b1;
                c = (u >= 64'sd4294967296);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4, 4'd5, 4'd11: begin
                if (o == 4'd5) cin = fl[1] ? 0 : 1;
                u = ua - ub - cin; s = sa - sb - cin;
                d = u[31:0]; arith = 1'b1;
                c = (u >= 0);
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6, 4'd12: d = a & b;
            4'd7: d = a | b;
            4'd8: d = a ^ b;
            4'd10: begin
                u = ua * ub;
                d = u[31:0];
            end
            default: e = 1'b1;
        endcase
        if (!e && upd) begin
            fl = arith ? {d[31], d == 0, c, v} : {d[31], d == 0, fl[1], fl[0]};
        end
    endfunction

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic sf);
        @(negedge clk);
        op = o; in1 = a; in2 = b; set_flags = sf; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({in_ready, out_valid, err, flags} !== 7'b1000000 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_during: rdy/vld/err/flags=%b data=%h want 1000000/0", {in_ready, out_valid, err, flags}, out_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_after: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        mf = 4'b0000;
    endtask

    task automatic test_arith();
        logic [3:0]  t_op [5] = '{4'd2, 4'd4, 4'd5, 4'd2, 4'd3};
        logic [31:0] t_a  [5] = '{32'h7FFFFFFF, 32'd5, 32'd7, 32'hFFFFFFFF, 32'd2};
        logic [31:0] t_b  [5] = '{32'h1, 32'd5, 32'd2, 32'h1, 32'd3};
        logic [31:0] t_d  [5] = '{32'h80000000, 32'd0, 32'd5, 32'd0, 32'd6};
        logic [3:0]  t_f  [5] = '{4'b1001, 4'b0110, 4'b0010, 4'b0110, 4'b0000};
        logic [31:0] d;
        logic        e;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            ref_model(t_op[i], t_a[i], t_b[i], 1'b1, mf, d, e);
            issue(t_op[i], t_a[i], t_b[i], 1'b1);
            wait_valid(lat);
            checks++;
            if (lat !== 0 || out_data !== t_d[i] || flags !== t_f[i] || err !== 1'b0) begin
                errors++;
                $display("FAIL arith[%0d]: lat=%0d data=%h flags=%b err=%b want 0 %h %b 0", i, lat, out_data, flags, err, t_d[i], t_f[i]);
            end
            pop();
        end
    endtask

    task automatic test_mul();
        logic [31:0] d;
        logic        e;
        int          lat;
        logic        rdy_seen;
        ref_model(4'd2, 32'h7FFFFFFF, 32'h1, 1'b1, mf, d, e);
        issue(4'd2, 32'h7FFFFFFF, 32'h1, 1'b1);
        wait_valid(lat);
        pop();
        ref_model(4'd10, 32'h00010000, 32'h00010003, 1'b1, mf, d, e);
        issue(4'd10, 32'h00010000, 32'h00010003, 1'b1);
        lat = 0; rdy_seen = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (in_ready !== 1'b0) rdy_seen = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat !== 32 || rdy_seen !== 1'b0) begin
            errors++;
            $display("FAIL mul_latency: edges=%0d in_ready_seen=%b want 32 0", lat, rdy_seen);
        end
        checks++;
        if (out_data !== 32'h00030000 || flags !== 4'b0001 || err !== 1'b0) begin
            errors++;
            $display("FAIL mul_result: data=%h flags=%b err=%b want 00030000 0001 0", out_data, flags, err);
        end
        pop();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        e;
        int          lat;
        ref_model(4'd2, 32'hFFFFFFFF, 32'h1, 1'b1, mf, d, e);
        issue(4'd2, 32'hFFFFFFFF, 32'h1, 1'b1);
        wait_valid(lat);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'd0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: vld=%b data=%h in_ready=%b want 1 0 0", i, out_valid, out_data, in_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        ref_model(4'd3, 32'd2, 32'd3, 1'b1, mf, d, e);
        out_ready = 1'b1; in_valid = 1'b1; op = 4'd3; in1 = 32'd2; in2 = 32'd3; set_flags = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== d || flags !== mf) begin
            errors++;
            $display("FAIL b2b_adc: vld=%b data=%h flags=%b want 1 %h %b", out_valid, out_data, flags, d, mf);
        end
        pop();
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] d;
        logic        e;
        int          lat;
        logic        vld_seen;
        ref_model(4'd2, 32'h7FFFFFFF, 32'h1, 1'b1, mf, d, e);
        issue(4'd2, 32'h7FFFFFFF, 32'h1, 1'b1);
        wait_valid(lat);
        pop();
        issue(4'd10, 32'h1234, 32'h5678, 1'b1);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || flags !== 4'b0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mul: vld=%b flags=%b in_ready=%b want 0 0000 1", out_valid, flags, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mf = 4'b0000;
        vld_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) vld_seen = 1'b1;
        end
        checks++;
        if (vld_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_discard: out_valid seen=%b want 0", vld_seen);
        end
    endtask

    task automatic test_flush();
        logic [31:0] d;
        logic        e;
        int          lat;
        logic        vld_seen;
        ref_model(4'd2, 32'h80000000, 32'h80000000, 1'b1, mf, d, e);
        issue(4'd2, 32'h80000000, 32'h80000000, 1'b1);
        wait_valid(lat);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || flags !== mf || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: vld=%b flags=%b in_ready=%b want 0 %b 1", out_valid, flags, in_ready, mf);
        end
        issue(4'd10, 32'd9, 32'd9, 1'b1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        vld_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) vld_seen = 1'b1;
        end
        checks++;
        if (vld_seen !== 1'b0 || flags !== mf) begin
            errors++;
            $display("FAIL flush_mul: vld_seen=%b flags=%b want 0 %b", vld_seen, flags, mf);
        end
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 4'd2; in1 = 32'd1; in2 = 32'd1; set_flags = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || flags !== mf) begin
            errors++;
            $display("FAIL flush_vs_accept: vld=%b flags=%b want 0 %b", out_valid, flags, mf);
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};
        logic [31:0] a, b, d;
        logic [3:0]  o;
        logic        sf, e;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            o  = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            sf = 1'($urandom_range(0, 1));
            ref_model(o, a, b, sf, mf, d, e);
            issue(o, a, b, sf);
            wait_valid(lat);
            checks++;
            if (lat !== ((o == 4'd10) ? 32 : 0) || out_data !== d || err !== e || flags !== mf) begin
                errors++;
                $display("FAIL random[%0d] op=%h a=%h b=%h sf=%b: lat=%0d data=%h err=%b flags=%b want data=%h err=%b flags=%b",
                         i, o, a, b, sf, lat, out_data, err, flags, d, e, mf);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            pop();
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
